interval_sched: RTL and testbench

- Shares one fp16 interval classifier (7 boundaries, one-hot 8-interval result) among NUM_REQ requesters.
- Owns the programmable boundary table.
- Round-robin arbitration, 2-stage pipeline with valid/ready backpressure, config writes serialized against in-flight traffic.
- Sits between activation-producing lanes and the interval-indexed lookup/scale logic.

---
 rtl/interval_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_interval_sched.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_sched.sv
// interval_sched: one fp16 interval classifier shared round-robin by NUM_REQ requesters
// through a 2-stage valid/ready pipeline. Define INTERVAL_SCHED_HIST_EN to add per-interval hit counters.
module interval_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int NUM_INT = 8,
    localparam int IDW    = $clog2(NUM_REQ),
    localparam int AW     = $clog2(NUM_INT)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef INTERVAL_SCHED_HIST_EN
    input  logic                     hist_clr_i,
    input  logic [AW-1:0]            hist_sel_i,
    output logic [15:0]              hist_cnt_o,
`endif
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDW-1:0]           rsp_id_o,
    output logic [NUM_INT-1:0]       rsp_interval_o,
    input  logic                     cfg_we_i,
    input  logic [AW-1:0]            cfg_addr_i,
    input  logic [WIDTH-1:0]         cfg_data_i,
    output logic                     cfg_ready_o,
    output logic                     busy_o
);

    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_found;
    logic                 grant_en;

    logic [WIDTH-1:0]     bnd [NUM_INT-1];
    logic                 cfg_commit;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_data;
    logic [IDW-1:0]       s1_id;
    logic [NUM_INT-1:0]   s1_interval;
    logic [AW-1:0]        s1_index;

    logic                 s2_load;
    logic                 s1_accept;

    // Maps fp16 onto an unsigned key whose ordering matches numeric ordering (-0 folds onto +0).
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] x);
        if (x == SIGN_BIT) begin
            order_key = SIGN_BIT;
        end else if (x[WIDTH-1]) begin
            order_key = ~x;
        end else begin
            order_key = x | SIGN_BIT;
        end
    endfunction

    assign busy_o    = s1_valid | rsp_valid_o;
    assign s2_load   = !rsp_valid_o || rsp_ready_i;
    assign s1_accept = !s1_valid || s2_load;

    // First valid requester at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        logic [IDW:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // A pending config write (or an ongoing drain) blocks new grants so the table update waits for an empty pipe.
    assign grant_en    = (state != DRAIN) && !cfg_we_i && s1_accept && grant_found;
    assign req_ready_o = (grant_en ? (NUM_REQ'(1) << grant_idx) : '0) & {NUM_REQ{rst_ni}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cfg_ready_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_we_i) begin
                    state_nxt = DRAIN;
                end else if (|req_valid_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cfg_we_i) begin
                    state_nxt = DRAIN;
                end else if (!busy_o && !(|req_valid_i)) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!cfg_we_i) begin
                    state_nxt = (busy_o || (|req_valid_i)) ? RUN : IDLE;
                end else if (!busy_o) begin
                    cfg_ready_o = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range addresses still complete the handshake but leave the table alone.
    assign cfg_commit = cfg_ready_o && (cfg_addr_i < AW'(NUM_INT-1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INT-1; i++) begin
                bnd[i] <= '0;
            end
        end else if (cfg_commit) begin
            bnd[cfg_addr_i] <= cfg_data_i;
        end
    end

    // Interval index is the number of boundaries the sample is at or above.
    always_comb begin
        s1_index    = '0;
        s1_interval = '0;
        for (int i = 0; i < NUM_INT-1; i++) begin
            if (order_key(s1_data) >= order_key(bnd[i])) begin
                s1_index = s1_index + AW'(1);
            end
        end
        s1_interval[s1_index] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else if (s1_accept) begin
            s1_valid <= grant_en;
            if (grant_en) begin
                s1_data <= req_data_i[grant_idx*WIDTH +: WIDTH];
                s1_id   <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o    <= 1'b0;
            rsp_id_o       <= '0;
            rsp_interval_o <= '0;
        end else if (s2_load) begin
            rsp_valid_o <= s1_valid;
            if (s1_valid) begin
                rsp_id_o       <= s1_id;
                rsp_interval_o <= s1_interval;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
        end
    end

`ifdef INTERVAL_SCHED_HIST_EN
    logic [15:0] hist_cnt [NUM_INT];

    // Clear wins over a same-cycle hit; counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INT; i++) begin
                hist_cnt[i] <= '0;
            end
        end else if (hist_clr_i) begin
            for (int i = 0; i < NUM_INT; i++) begin
                hist_cnt[i] <= '0;
            end
        end else if (rsp_valid_o && rsp_ready_i) begin
            for (int i = 0; i < NUM_INT; i++) begin
                if (rsp_interval_o[i] && (hist_cnt[i] != 16'hFFFF)) begin
                    hist_cnt[i] <= hist_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign hist_cnt_o = hist_cnt[hist_sel_i];
`endif

endmodule

// File: tb/tb_interval_sched.sv
// tb_interval_sched: random and directed stimulus for interval_sched checked against a queue-based reference model.
// Define INTERVAL_SCHED_HIST_EN to also exercise the histogram counters.
module tb_interval_sched;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int NI = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NR-1:0]   req_valid_i;
    logic [NR*W-1:0] req_data_i;
    logic [NR-1:0]   req_ready_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [1:0]      rsp_id_o;
    logic [NI-1:0]   rsp_interval_o;
    logic            cfg_we_i;
    logic [2:0]      cfg_addr_i;
    logic [W-1:0]    cfg_data_i;
    logic            cfg_ready_o;
    logic            busy_o;
`ifdef INTERVAL_SCHED_HIST_EN
    logic            hist_clr_i;
    logic [2:0]      hist_sel_i;
    logic [15:0]     hist_cnt_o;
`endif

    interval_sched #(.NUM_REQ(NR), .WIDTH(W), .NUM_INT(NI)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
`ifdef INTERVAL_SCHED_HIST_EN
        .hist_clr_i     (hist_clr_i),
        .hist_sel_i     (hist_sel_i),
        .hist_cnt_o     (hist_cnt_o),
`endif
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_id_o       (rsp_id_o),
        .rsp_interval_o (rsp_interval_o),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_data_i     (cfg_data_i),
        .cfg_ready_o    (cfg_ready_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: boundary table, rr pointer, and a queue of accepted samples in order.
    typedef struct {
        int            id;
        logic [NI-1:0] itv;
        int            born;
    } item_t;

    logic [W-1:0] tbl [NI-1];
    int           rr_ptr;
    int           cyc;
    bit           in_drain;
    item_t        sb[$];
    int           hist_model [NI];

    logic [NR-1:0] exp_ready, obs_ready;
    logic          exp_rv, obs_rv, exp_busy, obs_busy, exp_cfg_rdy, obs_cfg_rdy;
    int            head_id;
    logic [NI-1:0] head_itv, obs_itv;
    logic [1:0]    obs_id;
    int            exp_hist, obs_hist;

    function automatic real fp16_to_real(logic [15:0] x);
        real mag;
        real scale;
        int  e;
        e     = int'(x[14:10]);
        scale = 1.0;
        if (e == 0) begin
            mag = real'(x[9:0]);
            e   = 1;
        end else begin
            mag = 1024.0 + real'(x[9:0]);
        end
        for (int k = 0; k < 25; k++) scale = scale / 2.0;
        for (int k = 0; k < e; k++) scale = scale * 2.0;
        return x[15] ? -(mag * scale) : mag * scale;
    endfunction

    function automatic logic [NI-1:0] classify(logic [15:0] x);
        int  n;
        real v;
        n = 0;
        v = fp16_to_real(x);
        for (int i = 0; i < NI-1; i++) begin
            if (v >= fp16_to_real(tbl[i])) n++;
        end
        return NI'(1) << n;
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[14:10] == 5'h1F) v[14:10] = 5'h1E;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI-1; i++) tbl[i] = '0;
        rr_ptr   = 0;
        in_drain = 0;
        sb.delete();
        for (int i = 0; i < NI; i++) hist_model[i] = 0;
    endtask

    task automatic drive_idle();
        req_valid_i = '0;
        req_data_i  = '0;
        rsp_ready_i = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = '0;
        cfg_data_i  = '0;
`ifdef INTERVAL_SCHED_HIST_EN
        hist_clr_i  = 1'b0;
        hist_sel_i  = 3'd2;
`endif
    endtask

    // One clock: compute expectations for the current inputs, capture DUT outputs, advance the model.
    task automatic tick();
        int  n;
        int  idx;
        bit  found;
        #1;
        n         = sb.size();
        exp_ready = '0;
        found     = 0;
        if (!cfg_we_i && !in_drain && (n < 2 || rsp_ready_i)) begin
            for (int k = 0; k < NR; k++) begin
                idx = (rr_ptr + k) % NR;
                if (!found && req_valid_i[idx]) begin
                    exp_ready[idx] = 1'b1;
                    found          = 1;
                end
            end
        end
        exp_rv      = (n > 0) && (cyc - sb[0].born >= 2);
        head_id     = (n > 0) ? sb[0].id : 0;
        head_itv    = (n > 0) ? sb[0].itv : '0;
        exp_busy    = (n > 0);
        exp_cfg_rdy = cfg_we_i && in_drain && (n == 0);
        obs_ready   = req_ready_o;
        obs_rv      = rsp_valid_o;
        obs_id      = rsp_id_o;
        obs_itv     = rsp_interval_o;
        obs_busy    = busy_o;
        obs_cfg_rdy = cfg_ready_o;
`ifdef INTERVAL_SCHED_HIST_EN
        exp_hist = hist_model[hist_sel_i];
        obs_hist = int'(hist_cnt_o);
        if (hist_clr_i) begin
            for (int b = 0; b < NI; b++) hist_model[b] = 0;
        end else if (exp_rv && rsp_ready_i) begin
            for (int b = 0; b < NI; b++)
                if (head_itv[b] && hist_model[b] < 65535) hist_model[b]++;
        end
`endif
        if (exp_rv && rsp_ready_i) void'(sb.pop_front());
        for (int k = 0; k < NR; k++) begin
            if (exp_ready[k] && req_valid_i[k]) begin
                sb.push_back('{id: k, itv: classify(req_data_i[k*W +: W]), born: cyc});
                rr_ptr = (k + 1) % NR;
            end
        end
        if (exp_cfg_rdy && cfg_addr_i < 3'(NI-1)) tbl[cfg_addr_i] = cfg_data_i;
        in_drain = cfg_we_i && !exp_cfg_rdy;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data, output bit ok);
        bit done;
        done       = 0;
        ok         = 0;
        cfg_we_i   = 1'b1;
        cfg_addr_i = addr;
        cfg_data_i = data;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = obs_cfg_rdy || exp_cfg_rdy;
            ok   = obs_cfg_rdy && exp_cfg_rdy;
        end
        cfg_we_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if ({rsp_valid_o, rsp_id_o, rsp_interval_o, req_ready_o, cfg_ready_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%b id=%0d itv=%b rdy=%b cfg=%b busy=%b want all zero",
                     rsp_valid_o, rsp_id_o, rsp_interval_o, req_ready_o, cfg_ready_o, busy_o);
        end
        @(negedge clk_i);
        rst_ni      = 1'b1;
        req_valid_i = 4'hF;
        req_data_i  = {16'h4100, 16'hBC00, 16'h0000, 16'h3C00};
        for (int c = 0; c < 8; c++) begin
            if (c == 4) req_valid_i = '0;
            tick();
            if (c == 0) begin
                total++;
                if (obs_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL reset_first_grant got=%b want=0001", obs_ready);
                end
            end
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL reset_step cyc=%0d got rdy=%b rv=%b busy=%b id=%0d itv=%b want rdy=%b rv=%b busy=%b id=%0d itv=%b",
                         cyc, obs_ready, obs_rv, obs_busy, obs_id, obs_itv, exp_ready, exp_rv, exp_busy, head_id, head_itv);
            end
        end
    endtask

    task automatic test_table_load();
        logic [15:0] bvals   [7] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};
        logic [15:0] samples [5] = '{16'h4100, 16'h3800, 16'h4800, 16'h4000, 16'h3C00};
        logic [7:0]  want    [5] = '{8'b0000_0100, 8'b0000_0001, 8'b1000_0000, 8'b0000_0100, 8'b0000_0010};
        bit ok;
        for (int i = 0; i < 7; i++) begin
            cfg_write(3'(i), bvals[i], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL table_cfg_handshake addr=%0d got cfg_ready=%b want 1", i, obs_cfg_rdy);
            end
        end
        for (int s = 0; s < 5; s++) begin
            req_data_i  = '0;
            req_data_i[1*W +: W] = samples[s];
            req_valid_i = 4'b0010;
            for (int c = 0; c < 4; c++) begin
                tick();
                req_valid_i = '0;
                if (c == 2) begin
                    total++;
                    if (obs_rv !== 1'b1 || obs_id !== 2'd1 || obs_itv !== want[s]) begin
                        bad++;
                        $display("FAIL table_result sample=%h got rv=%b id=%0d itv=%b want rv=1 id=1 itv=%b",
                                 samples[s], obs_rv, obs_id, obs_itv, want[s]);
                    end
                end
                total++;
                if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                    (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                    bad++;
                    $display("FAIL table_step cyc=%0d got rdy=%b rv=%b busy=%b id=%0d itv=%b want rdy=%b rv=%b busy=%b id=%0d itv=%b",
                             cyc, obs_ready, obs_rv, obs_busy, obs_id, obs_itv, exp_ready, exp_rv, exp_busy, head_id, head_itv);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 12) begin
                req_valid_i = 4'hF;
                for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = rand_fp16();
            end else if (c < 15) begin
                req_valid_i = '0;
            end else if (c < 17) begin
                req_valid_i = 4'b0100;
            end else begin
                req_valid_i = '0;
            end
            tick();
            if (c == 16) begin
                total++;
                if (obs_ready !== 4'b0100) begin
                    bad++;
                    $display("FAIL rr_lone_req2 got=%b want=0100", obs_ready);
                end
            end
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL rr_step cyc=%0d got rdy=%b rv=%b busy=%b id=%0d itv=%b want rdy=%b rv=%b busy=%b id=%0d itv=%b",
                         cyc, obs_ready, obs_rv, obs_busy, obs_id, obs_itv, exp_ready, exp_rv, exp_busy, head_id, head_itv);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]    held_id;
        logic [NI-1:0] held_itv;
        held_id  = '0;
        held_itv = '0;
        for (int c = 0; c < 18; c++) begin
            req_valid_i = (c < 12) ? 4'hF : 4'h0;
            for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = rand_fp16();
            rsp_ready_i = (c < 5) ? 1'b0 : 1'b1;
            tick();
            if (c == 2) begin
                held_id  = obs_id;
                held_itv = obs_itv;
            end
            if (c == 4) begin
                total++;
                if (obs_ready !== '0 || obs_rv !== 1'b1 || obs_id !== held_id || obs_itv !== held_itv) begin
                    bad++;
                    $display("FAIL bp_hold got rdy=%b rv=%b id=%0d itv=%b want rdy=0000 rv=1 id=%0d itv=%b",
                             obs_ready, obs_rv, obs_id, obs_itv, held_id, held_itv);
                end
            end
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL bp_step cyc=%0d got rdy=%b rv=%b busy=%b id=%0d itv=%b want rdy=%b rv=%b busy=%b id=%0d itv=%b",
                         cyc, obs_ready, obs_rv, obs_busy, obs_id, obs_itv, exp_ready, exp_rv, exp_busy, head_id, head_itv);
            end
        end
    endtask

    task automatic test_cfg_drain();
        bit done;
        done        = 0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = 16'h4280;
        req_valid_i = 4'b0011;
        for (int c = 0; c < 24 && !done; c++) begin
            if (c == 2) begin
                cfg_we_i   = 1'b1;
                cfg_addr_i = 3'd2;
                cfg_data_i = 16'h4300;
            end
            tick();
            done = obs_cfg_rdy || exp_cfg_rdy;
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL drain_step cyc=%0d got rdy=%b rv=%b busy=%b cfg=%b itv=%b want rdy=%b rv=%b busy=%b cfg=%b itv=%b",
                         cyc, obs_ready, obs_rv, obs_busy, obs_cfg_rdy, obs_itv, exp_ready, exp_rv, exp_busy, exp_cfg_rdy, head_itv);
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout got cfg_ready=%b want 1 within 24 cycles", obs_cfg_rdy);
        end
        cfg_we_i    = 1'b0;
        req_valid_i = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid_i = '0;
            if (c == 2) begin
                total++;
                if (obs_rv !== 1'b1 || obs_id !== 2'd3 || obs_itv !== 8'b0000_0100) begin
                    bad++;
                    $display("FAIL drain_new_table got rv=%b id=%0d itv=%b want rv=1 id=3 itv=00000100", obs_rv, obs_id, obs_itv);
                end
            end
        end
    endtask

    task automatic test_bad_addr();
        bit ok;
        cfg_write(3'd7, 16'h3800, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL badaddr_handshake got cfg_ready=%b want 1", obs_cfg_rdy);
        end
        req_data_i[0 +: W] = 16'h4100;
        req_valid_i        = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid_i = '0;
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL badaddr_step cyc=%0d got rv=%b id=%0d itv=%b want rv=%b id=%0d itv=%b",
                         cyc, obs_rv, obs_id, obs_itv, exp_rv, head_id, head_itv);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid_i = (c < 390) ? 4'($urandom) : 4'h0;
            for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = rand_fp16();
            rsp_ready_i = (c >= 390) || ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy || obs_cfg_rdy !== exp_cfg_rdy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL random_step cyc=%0d got rdy=%b rv=%b busy=%b id=%0d itv=%b want rdy=%b rv=%b busy=%b id=%0d itv=%b",
                         cyc, obs_ready, obs_rv, obs_busy, obs_id, obs_itv, exp_ready, exp_rv, exp_busy, head_id, head_itv);
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready_i = 1'b1;
        req_valid_i = 4'hF;
        for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = 16'h4100;
        repeat (3) tick();
        rst_ni = 1'b0;
        #1;
        total++;
        if ({rsp_valid_o, rsp_id_o, rsp_interval_o, req_ready_o, cfg_ready_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got rv=%b id=%0d itv=%b rdy=%b cfg=%b busy=%b want all zero",
                     rsp_valid_o, rsp_id_o, rsp_interval_o, req_ready_o, cfg_ready_o, busy_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) req_valid_i = '0;
            tick();
            if (c == 0) begin
                total++;
                if (obs_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL midreset_pointer got=%b want=0001", obs_ready);
                end
            end
            if (c == 2) begin
                total++;
                if (obs_rv !== 1'b1 || obs_itv !== 8'b1000_0000) begin
                    bad++;
                    $display("FAIL midreset_table_zero got rv=%b itv=%b want rv=1 itv=10000000", obs_rv, obs_itv);
                end
            end
            total++;
            if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_busy !== exp_busy ||
                (exp_rv && (obs_id !== 2'(head_id) || obs_itv !== head_itv))) begin
                bad++;
                $display("FAIL midreset_step cyc=%0d got rdy=%b rv=%b id=%0d itv=%b want rdy=%b rv=%b id=%0d itv=%b",
                         cyc, obs_ready, obs_rv, obs_id, obs_itv, exp_ready, exp_rv, head_id, head_itv);
            end
        end
    endtask

`ifdef INTERVAL_SCHED_HIST_EN
    task automatic test_hist();
        logic [15:0] bvals [7] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};
        bit ok;
        for (int i = 0; i < 7; i++) cfg_write(3'(i), bvals[i], ok);
        hist_sel_i = 3'd2;
        hist_clr_i = 1'b1;
        tick();
        hist_clr_i = 1'b0;
        for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = 16'h4100;
        for (int c = 0; c < 12; c++) begin
            req_valid_i = (c < 3) ? 4'b0001 : 4'b0000;
            rsp_ready_i = !(c >= 2 && c < 5);
            hist_clr_i  = (c == 10);
            tick();
            total++;
            if (obs_hist !== exp_hist) begin
                bad++;
                $display("FAIL hist_count cyc=%0d got=%0d want=%0d", cyc, obs_hist, exp_hist);
            end
        end
        total++;
        if (obs_hist !== 0) begin
            bad++;
            $display("FAIL hist_clear got=%0d want=0", obs_hist);
        end
        hist_clr_i = 1'b0;
    endtask
`endif

    initial begin
        cyc = 0;
        test_reset();
        test_table_load();
        test_round_robin();
        test_backpressure();
        test_cfg_drain();
        test_bad_addr();
        test_random();
        test_reset_mid();
`ifdef INTERVAL_SCHED_HIST_EN
        test_hist();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
